// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  // Which CPU port owns the access in progress for a busy state.
  function automatic logic busy_port(arb_state_t s);
    return (s == DM_BUSY) ? PORT_DM : PORT_IF;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the memory model.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_cancel;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              err_timeout;

  modport slave (
    input  if_req, if_addr, if_cancel, dm_req, dm_we, dm_addr, dm_wdata,
           mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready,
           mem_req, mem_we, mem_addr, mem_wdata, err_timeout
  );

  modport master (
    output if_req, if_addr, if_cancel, dm_req, dm_we, dm_addr, dm_wdata,
           mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
           mem_req, mem_we, mem_addr, mem_wdata, err_timeout
  );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog: down-counter loaded at grant, terminal count at zero.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  input  logic count,
  output logic tc
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Loading TIMEOUT_CYCLES-1 makes tc assert during the last allowed busy cycle.
  always_ff @(posedge clk) begin
    if (!reset)                   cnt <= '0;
    else if (load)                cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
    else if (clear)               cnt <= '0;
    else if (count && cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for CPU fetch and data ports, data has priority.
// Optional busy watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no access; grant data first, then an uncancelled fetch
// IF_BUSY | fetch on the memory bus, waiting for mem_ack
// DM_BUSY | load/store on the memory bus, waiting for mem_ack
// RESP    | one-cycle ready pulse to the granted port, no grants
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);
  arb_state_t state, next_state;

  logic              busy, done, drop_now, timeout;
  logic [DATA_W-1:0] resp_data;

  logic              drop, drop_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d, dm_ready_q, dm_ready_d;
  logic              err_q, err_d;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  assign busy      = (state == IF_BUSY) || (state == DM_BUSY);
  assign done      = bus.mem_ack || timeout;
  assign drop_now  = drop || bus.if_cancel;
  // A forced (timed-out) completion returns zero data.
  assign resp_data = bus.mem_ack ? bus.mem_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  logic wd_tc;

  mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .load  (state == IDLE && next_state != IDLE),
    .clear (busy && done),
    .count (busy),
    .tc    (wd_tc)
  );

  assign timeout = busy && wd_tc;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      drop        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= next_state;
      drop        <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.dm_req)                         next_state = DM_BUSY;
        else if (bus.if_req && !bus.if_cancel)  next_state = IF_BUSY;
      end
      IF_BUSY: if (done) next_state = drop_now ? IDLE : RESP;
      DM_BUSY: if (done) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    drop_d      = drop;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    err_d       = err_q || (timeout && !bus.mem_ack);
    case (state)
      IDLE: begin
        if (next_state == DM_BUSY) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
        end else if (next_state == IF_BUSY) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (done) begin
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          if (busy_port(state) == PORT_DM) begin
            dm_ready_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = resp_data;
          end else if (!drop_now) begin
            if_ready_d = 1'b1;
            if_rdata_d = resp_data;
          end
        end else if (state == IF_BUSY && bus.if_cancel) begin
          drop_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.if_ready    = if_ready_q;
  assign bus.dm_ready    = dm_ready_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; covers the timeout path when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TO_CYC = 4;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.if_cancel = 1'b0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("rst_mem_req",  32'(bus.mem_req), 0);
    chk("rst_mem_we",   32'(bus.mem_we), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_if_ready", 32'(bus.if_ready), 0);
    chk("rst_dm_ready", 32'(bus.dm_ready), 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);
    chk("rst_err",      32'(bus.err_timeout), 0);

    // Fetch, acked in second busy cycle
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    tick();
    chk("f_req1",  32'(bus.mem_req), 1);
    chk("f_addr",  bus.mem_addr, 32'h8);
    chk("f_we1",   32'(bus.mem_we), 0);
    chk("f_rdy1",  32'(bus.if_ready), 0);
    tick();
    chk("f_req2",  32'(bus.mem_req), 1);
    chk("f_we2",   32'(bus.mem_we), 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0010_0093;
    tick();
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    chk("f_req3",   32'(bus.mem_req), 0);
    chk("f_ready",  32'(bus.if_ready), 1);
    chk("f_rdata",  bus.if_rdata, 32'h0010_0093);
    chk("f_dm_rdy", 32'(bus.dm_ready), 0);
    tick();
    chk("f_ready_end", 32'(bus.if_ready), 0);

    // Simultaneous requests: data first
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h4;
    tick();
    chk("p_addr_dm", bus.mem_addr, 32'h4);
    chk("p_req_dm",  32'(bus.mem_req), 1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
    tick();
    bus.mem_ack = 1'b0; bus.dm_req = 1'b0;
    chk("p_dm_ready", 32'(bus.dm_ready), 1);
    chk("p_dm_rdata", bus.dm_rdata, 32'h1111_1111);
    chk("p_if_early", 32'(bus.if_ready), 0);
    tick();
    chk("p_idle_req", 32'(bus.mem_req), 0);
    chk("p_idle_if",  32'(bus.if_ready), 0);
    tick();
    chk("p_addr_if", bus.mem_addr, 32'h10);
    chk("p_req_if",  32'(bus.mem_req), 1);
    chk("p_if_wait", 32'(bus.if_ready), 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h2222_2222;
    tick();
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    chk("p_if_ready", 32'(bus.if_ready), 1);
    chk("p_if_rdata", bus.if_rdata, 32'h2222_2222);
    tick();

    // Store
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h8; bus.dm_wdata = 32'h3;
    tick();
    chk("s_we",    32'(bus.mem_we), 1);
    chk("s_wdata", bus.mem_wdata, 32'h3);
    chk("s_addr",  bus.mem_addr, 32'h8);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
    tick();
    bus.mem_ack = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    chk("s_ready", 32'(bus.dm_ready), 1);
    chk("s_rdata", bus.dm_rdata, 32'h1111_1111);
    tick();

    // Cancelled fetch, then a normal one
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    tick();
    chk("c_req", 32'(bus.mem_req), 1);
    bus.if_cancel = 1'b1;
    tick();
    bus.if_cancel = 1'b0; bus.if_req = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_ack = 1'b0;
    chk("c_no_ready", 32'(bus.if_ready), 0);
    chk("c_rdata",    bus.if_rdata, 32'h2222_2222);
    chk("c_req_low",  32'(bus.mem_req), 0);
    bus.if_req = 1'b1; bus.if_addr = 32'h24;
    tick();
    chk("c2_addr", bus.mem_addr, 32'h24);
    chk("c2_req",  32'(bus.mem_req), 1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_ack = 1'b0; bus.if_req = 1'b0;
    chk("c2_ready", 32'(bus.if_ready), 1);
    chk("c2_rdata", bus.if_rdata, 32'h1234_5678);
    tick();

    // Reset during a data access, then a late ack
    bus.dm_req = 1'b1; bus.dm_addr = 32'h30; bus.dm_wdata = 32'h77;
    tick();
    chk("r_req", 32'(bus.mem_req), 1);
    tick();
    reset = 1'b0;
    tick();
    chk("r_mem_req",   32'(bus.mem_req), 0);
    chk("r_mem_addr",  bus.mem_addr, 0);
    chk("r_mem_wdata", bus.mem_wdata, 0);
    chk("r_if_rdata",  bus.if_rdata, 0);
    chk("r_dm_rdata",  bus.dm_rdata, 0);
    chk("r_dm_ready",  32'(bus.dm_ready), 0);
    reset = 1'b1; bus.dm_req = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h9999_9999;
    tick();
    bus.mem_ack = 1'b0;
    chk("r_late_dm", 32'(bus.dm_ready), 0);
    chk("r_late_if", 32'(bus.if_ready), 0);
    tick();
    chk("r_late_dm2", 32'(bus.dm_ready), 0);
    chk("r_late_req", 32'(bus.mem_req), 0);

    // Quick load so the zero timeout data is observable
    bus.dm_req = 1'b1; bus.dm_addr = 32'h3C;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55;
    tick();
    bus.mem_ack = 1'b0; bus.dm_req = 1'b0;
    chk("l_rdata", bus.dm_rdata, 32'h55);
    tick();

    bus.dm_req = 1'b1; bus.dm_addr = 32'h40;
`ifdef MEM_ARB_TIMEOUT_EN
    tick(); tick(); tick(); tick();
    chk("t_req4",   32'(bus.mem_req), 1);
    chk("t_rdy4",   32'(bus.dm_ready), 0);
    chk("t_err4",   32'(bus.err_timeout), 0);
    tick();
    bus.dm_req = 1'b0;
    chk("t_ready",  32'(bus.dm_ready), 1);
    chk("t_rdata",  bus.dm_rdata, 0);
    chk("t_req",    32'(bus.mem_req), 0);
    chk("t_err",    32'(bus.err_timeout), 1);
    tick(); tick(); tick();
    chk("t_err_sticky", 32'(bus.err_timeout), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t_err_rst", 32'(bus.err_timeout), 0);
`else
    for (int i = 0; i < 10; i++) tick();
    chk("w_req",   32'(bus.mem_req), 1);
    chk("w_ready", 32'(bus.dm_ready), 0);
    chk("w_err",   32'(bus.err_timeout), 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h6666_0000;
    tick();
    bus.mem_ack = 1'b0; bus.dm_req = 1'b0;
    chk("w_ready2", 32'(bus.dm_ready), 1);
    chk("w_rdata",  bus.dm_rdata, 32'h6666_0000);
    chk("w_err2",   32'(bus.err_timeout), 0);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
